// File: rtl/icache_sa.sv
// Set-associative instruction cache: combinational hit path, multi-beat line refill
// with invalid-first/round-robin replacement, fence.i flush walk and saturating counters.
`timescale 1ns/1ps
module icache_sa #(
   parameter int unsigned WAYS       = 2,
   parameter int unsigned SETS       = 16,
   parameter int unsigned LINE_WORDS = 8,
   parameter logic [31:0] NOP_WORD   = 32'h00000013
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] PC,
   input  logic        fetch_en,
   input  logic        flush,
   output logic [31:0] rd,
   output logic        hit,
   output logic        stall,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_valid,
   input  logic [31:0] mem_rdata,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt,
   output logic [1:0]  dbg_state
);
   localparam int unsigned OFF = $clog2(LINE_WORDS);
   localparam int unsigned IDX = $clog2(SETS);
   localparam int unsigned LW  = 30 - OFF;
   localparam int unsigned TAG = LW - IDX;
   localparam int unsigned WW  = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef enum logic [1:0] {LOOKUP = 2'd0, REFILL = 2'd1, FLUSH = 2'd2} state_e;

   state_e          state_q, state_d;
   logic [LW-1:0]   line_q, line_d;
   logic [WW-1:0]   victim_q, victim_d;
   logic            all_valid_q, all_valid_d;
   logic [OFF-1:0]  beat_q, beat_d;
   logic [IDX-1:0]  fidx_q, fidx_d;
   logic            pend_q, pend_d;
   logic            mem_req_q, mem_req_d;
   logic [31:0]     hit_cnt_q, hit_cnt_d;
   logic [31:0]     miss_cnt_q, miss_cnt_d;
   logic [WAYS-1:0] valid_q [SETS];
   logic [WAYS-1:0] valid_d [SETS];
   logic [WW-1:0]   vptr_q [SETS];
   logic [WW-1:0]   vptr_d [SETS];

   logic [31:0]     data_mem [WAYS][SETS][LINE_WORDS];
   logic [TAG-1:0]  tag_mem [WAYS][SETS];
   logic            data_we, tag_we;

   logic [OFF-1:0]  pc_off;
   logic [IDX-1:0]  pc_idx;
   logic [TAG-1:0]  pc_tag;
   logic [IDX-1:0]  ref_idx;
   logic            unused_pc_lo;

   assign pc_off       = PC[2 +: OFF];
   assign pc_idx       = PC[2+OFF +: IDX];
   assign pc_tag       = PC[31 -: TAG];
   assign ref_idx      = line_q[IDX-1:0];
   assign unused_pc_lo = ^PC[1:0];

   logic            any_match;
   logic [31:0]     hit_word;
   logic [WW-1:0]   miss_victim;

   // Descending scan so the lowest-numbered matching/invalid way wins.
   always_comb begin
      any_match   = 1'b0;
      hit_word    = NOP_WORD;
      miss_victim = vptr_q[pc_idx];
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid_q[pc_idx][w] && (tag_mem[w][pc_idx] == pc_tag)) begin
            any_match = 1'b1;
            hit_word  = data_mem[w][pc_idx][pc_off];
         end
         if (!valid_q[pc_idx][w]) miss_victim = WW'(w);
      end
   end

   // Refill handshake: mem_req is a level held for the whole refill; a beat transfers on
   // every cycle mem_valid is high while in REFILL. There is no backpressure toward memory.
   always_comb begin
      state_d     = state_q;
      line_d      = line_q;
      victim_d    = victim_q;
      all_valid_d = all_valid_q;
      beat_d      = beat_q;
      fidx_d      = fidx_q;
      pend_d      = pend_q;
      hit_cnt_d   = hit_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      valid_d     = valid_q;
      vptr_d      = vptr_q;
      data_we     = 1'b0;
      tag_we      = 1'b0;
      hit         = 1'b0;
      stall       = 1'b0;
      rd          = NOP_WORD;
      unique case (state_q)
         LOOKUP: begin
            if (flush) begin
               state_d = FLUSH;
               fidx_d  = '0;
            end else if (fetch_en && any_match) begin
               hit = 1'b1;
               rd  = hit_word;
               if (hit_cnt_q != 32'hFFFFFFFF) hit_cnt_d = hit_cnt_q + 32'd1;
            end else if (fetch_en) begin
               stall       = 1'b1;
               line_d      = PC[31:2+OFF];
               victim_d    = miss_victim;
               all_valid_d = &valid_q[pc_idx];
               beat_d      = '0;
               pend_d      = 1'b0;
               state_d     = REFILL;
               if (miss_cnt_q != 32'hFFFFFFFF) miss_cnt_d = miss_cnt_q + 32'd1;
            end
         end
         REFILL: begin
            stall = 1'b1;
            if (flush) pend_d = 1'b1;
            if (mem_valid) begin
               data_we = 1'b1;
               beat_d  = beat_q + 1'b1;
               if (beat_q == OFF'(LINE_WORDS - 1)) begin
                  tag_we                     = 1'b1;
                  valid_d[ref_idx][victim_q] = 1'b1;
                  if (all_valid_q) vptr_d[ref_idx] = (WAYS > 1) ? victim_q + 1'b1 : '0;
                  state_d = (pend_q || flush) ? FLUSH : LOOKUP;
                  fidx_d  = '0;
                  pend_d  = 1'b0;
               end
            end
         end
         FLUSH: begin
            stall           = 1'b1;
            valid_d[fidx_q] = '0;
            vptr_d[fidx_q]  = '0;
            fidx_d          = fidx_q + 1'b1;
            if (fidx_q == IDX'(SETS - 1)) state_d = LOOKUP;
         end
         default: state_d = LOOKUP;
      endcase
   end

   assign mem_req_d = (state_d == REFILL);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q     <= LOOKUP;
         line_q      <= '0;
         victim_q    <= '0;
         all_valid_q <= 1'b0;
         beat_q      <= '0;
         fidx_q      <= '0;
         pend_q      <= 1'b0;
         mem_req_q   <= 1'b0;
         hit_cnt_q   <= '0;
         miss_cnt_q  <= '0;
         valid_q     <= '{default: '0};
         vptr_q      <= '{default: '0};
      end else begin
         state_q     <= state_d;
         line_q      <= line_d;
         victim_q    <= victim_d;
         all_valid_q <= all_valid_d;
         beat_q      <= beat_d;
         fidx_q      <= fidx_d;
         pend_q      <= pend_d;
         mem_req_q   <= mem_req_d;
         hit_cnt_q   <= hit_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
         valid_q     <= valid_d;
         vptr_q      <= vptr_d;
      end
   end

   // Storage arrays carry no reset; the valid bits alone qualify their contents.
   always_ff @(posedge CLK) begin
      if (data_we) data_mem[victim_q][ref_idx][beat_q] <= mem_rdata;
      if (tag_we)  tag_mem[victim_q][ref_idx]          <= line_q[LW-1 -: TAG];
   end

   assign mem_req   = mem_req_q;
   assign mem_addr  = {line_q, {(2 + OFF){1'b0}}};
   assign hit_cnt   = hit_cnt_q;
   assign miss_cnt  = miss_cnt_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_icache_sa.sv
// Bench for icache_sa (default parameters): directed scenarios plus a randomized run
// against a per-set replacement model.
`timescale 1ns/1ps
module tb_icache_sa;
   localparam int WAYS = 2;
   localparam int SETS = 16;
   localparam int LW   = 8;
   localparam logic [31:0] NOP = 32'h00000013;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [31:0] PC = '0;
   logic        fetch_en = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] rd;
   logic        hit;
   logic        stall;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_valid = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;
   logic [1:0]  dbg_state;

   int checks = 0;
   int failures = 0;

   icache_sa #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LW), .NOP_WORD(NOP)) dut (
      .CLK(CLK), .RST(RST), .PC(PC), .fetch_en(fetch_en), .flush(flush),
      .rd(rd), .hit(hit), .stall(stall), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_valid(mem_valid), .mem_rdata(mem_rdata), .hit_cnt(hit_cnt),
      .miss_cnt(miss_cnt), .dbg_state(dbg_state)
   );

   always #5 CLK = ~CLK;

   // Reference model: per set, which tags are resident in which way, plus round-robin pointer.
   bit          m_valid [SETS][WAYS];
   int unsigned m_tag   [SETS][WAYS];
   int          m_vptr  [SETS];
   logic [31:0] m_hits, m_misses;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h12345678;
   endfunction

   task automatic model_clear();
      for (int s = 0; s < SETS; s++) begin
         m_vptr[s] = 0;
         for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b0; PC = '0; fetch_en = 1'b0; flush = 1'b0; mem_valid = 1'b0; mem_rdata = '0;
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      model_clear();
      m_hits = '0; m_misses = '0;
   endtask

   task automatic lookup(input logic [31:0] pc, input bit fe, input bit fl,
                         output logic o_hit, output logic [31:0] o_rd, output logic o_stall);
      @(negedge CLK);
      PC = pc; fetch_en = fe; flush = fl;
      #1;
      o_hit = hit; o_rd = rd; o_stall = stall;
      @(posedge CLK);
      #1;
      fetch_en = 1'b0; flush = 1'b0;
   endtask

   // Supplies refill beats; reports whether mem_req/mem_addr/stall looked right on every beat.
   task automatic feed_beats(input logic [31:0] base, input int n_beats, input int gap_beat,
                             input int flush_beat, input bit directed,
                             output bit req_ok, output bit stall_ok);
      req_ok = 1'b1; stall_ok = 1'b1;
      for (int b = 0; b < n_beats; b++) begin
         if (b == gap_beat) begin
            @(negedge CLK);
            mem_valid = 1'b0;
            #1;
            if (mem_req !== 1'b1 || mem_addr !== base) req_ok = 1'b0;
            if (stall !== 1'b1 || hit !== 1'b0) stall_ok = 1'b0;
         end
         @(negedge CLK);
         mem_valid = 1'b1;
         mem_rdata = directed ? 32'hA0 + 32'(b) : mem_word(base + 32'(4 * b));
         flush = (b == flush_beat);
         #1;
         if (mem_req !== 1'b1 || mem_addr !== base) req_ok = 1'b0;
         if (stall !== 1'b1 || hit !== 1'b0) stall_ok = 1'b0;
      end
      @(posedge CLK);
      #1;
      mem_valid = 1'b0; flush = 1'b0;
   endtask

   task automatic fill(input logic [31:0] pc, output logic o_hit, output bit ok);
      logic [31:0] r;
      logic        s;
      bit          rq, st;
      lookup(pc, 1'b1, 1'b0, o_hit, r, s);
      feed_beats({pc[31:5], 5'b0}, LW, -1, -1, 1'b0, rq, st);
      ok = rq && st && (s === 1'b1);
   endtask

   task automatic count_stall(output int n);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         #1;
         if (stall === 1'b1) n++;
         else break;
      end
   endtask

   task automatic test_reset();
      @(negedge CLK);
      #1;
      checks++; if (hit !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL reset_hit_stall: got %b%b want 00", hit, stall); end
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
      checks++; if (rd !== NOP) begin failures++; $display("FAIL reset_rd: got %h want %h", rd, NOP); end
      checks++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin failures++; $display("FAIL reset_cnt: got %h/%h want 0/0", hit_cnt, miss_cnt); end
      @(negedge CLK);
      RST = 1'b1;
   endtask

   task automatic test_miss_refill();
      logic h, s; logic [31:0] r; bit rq, st;
      do_reset();
      lookup(32'h100, 1'b1, 1'b0, h, r, s);
      checks++; if (h !== 1'b0 || s !== 1'b1 || r !== NOP) begin failures++; $display("FAIL miss_lookup: got hit=%b stall=%b rd=%h want 0 1 %h", h, s, r, NOP); end
      checks++; if (miss_cnt !== 32'd1) begin failures++; $display("FAIL miss_cnt: got %0d want 1", miss_cnt); end
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin failures++; $display("FAIL miss_req: got req=%b addr=%h want 1 100", mem_req, mem_addr); end
      feed_beats(32'h100, LW, 4, -1, 1'b1, rq, st);
      checks++; if (!(rq && st)) begin failures++; $display("FAIL refill_beats: got req_ok=%b stall_ok=%b want 1 1", rq, st); end
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL refill_req_drop: got %b want 0", mem_req); end
      lookup(32'h100, 1'b1, 1'b0, h, r, s);
      checks++; if (h !== 1'b1 || r !== 32'hA0 || s !== 1'b0) begin failures++; $display("FAIL hit_word0: got hit=%b rd=%h stall=%b want 1 a0 0", h, r, s); end
      lookup(32'h11C, 1'b1, 1'b0, h, r, s);
      checks++; if (h !== 1'b1 || r !== 32'hA7) begin failures++; $display("FAIL hit_word7: got hit=%b rd=%h want 1 a7", h, r); end
      checks++; if (hit_cnt !== 32'd2 || miss_cnt !== 32'd1) begin failures++; $display("FAIL miss_refill_cnt: got %0d/%0d want 2/1", hit_cnt, miss_cnt); end
   endtask

   task automatic test_replacement();
      logic h, s; logic [31:0] r; bit ok;
      do_reset();
      fill(32'h000, h, ok);
      fill(32'h200, h, ok);
      fill(32'h400, h, ok);
      checks++; if (!ok || h !== 1'b0) begin failures++; $display("FAIL repl_third_fill: got hit=%b ok=%b want 0 1", h, ok); end
      lookup(32'h200, 1'b1, 1'b0, h, r, s);
      checks++; if (h !== 1'b1 || r !== mem_word(32'h200)) begin failures++; $display("FAIL repl_keep_200: got hit=%b rd=%h want 1 %h", h, r, mem_word(32'h200)); end
      fill(32'h000, h, ok);
      checks++; if (h !== 1'b0 || !ok) begin failures++; $display("FAIL repl_000_evicted: got hit=%b ok=%b want 0 1", h, ok); end
      lookup(32'h404, 1'b1, 1'b0, h, r, s);
      checks++; if (h !== 1'b1 || r !== mem_word(32'h404)) begin failures++; $display("FAIL repl_keep_400: got hit=%b rd=%h want 1 %h", h, r, mem_word(32'h404)); end
      fill(32'h200, h, ok);
      checks++; if (h !== 1'b0) begin failures++; $display("FAIL repl_200_evicted: got hit=%b want 0", h); end
      checks++; if (miss_cnt !== 32'd5 || hit_cnt !== 32'd2) begin failures++; $display("FAIL repl_cnt: got %0d/%0d want 5/2", miss_cnt, hit_cnt); end
   endtask

   task automatic test_flush();
      logic h, s; logic [31:0] r; bit ok, rq, st; int n;
      do_reset();
      fill(32'h100, h, ok);
      lookup(32'h100, 1'b1, 1'b1, h, r, s);
      checks++; if (h !== 1'b0) begin failures++; $display("FAIL flush_hit_forced: got %b want 0", h); end
      count_stall(n);
      checks++; if (n != SETS) begin failures++; $display("FAIL flush_stall_len: got %0d want %0d", n, SETS); end
      checks++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd1) begin failures++; $display("FAIL flush_cnt: got %0d/%0d want 0/1", hit_cnt, miss_cnt); end
      lookup(32'h100, 1'b1, 1'b0, h, r, s);
      checks++; if (h !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h100) begin failures++; $display("FAIL flush_remiss: got hit=%b req=%b addr=%h want 0 1 100", h, mem_req, mem_addr); end
      feed_beats(32'h100, LW, -1, -1, 1'b0, rq, st);
      lookup(32'h300, 1'b1, 1'b1, h, r, s);
      count_stall(n);
      checks++; if (n != SETS || miss_cnt !== 32'd2 || mem_req !== 1'b0) begin failures++; $display("FAIL flush_over_miss: got stalls=%0d miss=%0d req=%b want %0d 2 0", n, miss_cnt, mem_req, SETS); end
   endtask

   task automatic test_flush_in_refill();
      logic h, s; logic [31:0] r; bit rq, st; int n;
      do_reset();
      lookup(32'h100, 1'b1, 1'b0, h, r, s);
      feed_beats(32'h100, LW, -1, 5, 1'b0, rq, st);
      checks++; if (!(rq && st)) begin failures++; $display("FAIL pend_beats: got req_ok=%b stall_ok=%b want 1 1", rq, st); end
      count_stall(n);
      checks++; if (n != SETS) begin failures++; $display("FAIL pend_flush_len: got %0d want %0d", n, SETS); end
      lookup(32'h100, 1'b1, 1'b0, h, r, s);
      checks++; if (h !== 1'b0 || s !== 1'b1 || miss_cnt !== 32'd2) begin failures++; $display("FAIL pend_remiss: got hit=%b stall=%b miss=%0d want 0 1 2", h, s, miss_cnt); end
      feed_beats(32'h100, LW, -1, -1, 1'b0, rq, st);
   endtask

   task automatic test_reset_mid_refill();
      logic h, s; logic [31:0] r; bit rq, st;
      do_reset();
      lookup(32'h100, 1'b1, 1'b0, h, r, s);
      feed_beats(32'h100, 4, -1, -1, 1'b0, rq, st);
      @(negedge CLK);
      RST = 1'b0;
      #1;
      checks++; if (mem_req !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL rst_abort: got req=%b stall=%b want 0 0", mem_req, stall); end
      @(negedge CLK);
      RST = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         mem_valid = 1'b1; mem_rdata = 32'hDEAD0000 + 32'(i);
      end
      @(negedge CLK);
      mem_valid = 1'b0;
      lookup(32'h100, 1'b1, 1'b0, h, r, s);
      checks++; if (h !== 1'b0 || s !== 1'b1 || miss_cnt !== 32'd1) begin failures++; $display("FAIL rst_remiss: got hit=%b stall=%b miss=%0d want 0 1 1", h, s, miss_cnt); end
      feed_beats(32'h100, LW, -1, -1, 1'b0, rq, st);
      lookup(32'h108, 1'b1, 1'b0, h, r, s);
      checks++; if (h !== 1'b1 || r !== mem_word(32'h108)) begin failures++; $display("FAIL rst_refill_data: got hit=%b rd=%h want 1 %h", h, r, mem_word(32'h108)); end
   endtask

   task automatic test_saturation();
      logic h, s; logic [31:0] r; bit ok, rq, st;
      do_reset();
      fill(32'h100, h, ok);
      @(negedge CLK);
      force dut.hit_cnt_q = 32'hFFFFFFFE;
      #1;
      release dut.hit_cnt_q;
      for (int i = 0; i < 3; i++) lookup(32'h104, 1'b1, 1'b0, h, r, s);
      checks++; if (hit_cnt !== 32'hFFFFFFFF) begin failures++; $display("FAIL sat_hit: got %h want ffffffff", hit_cnt); end
      for (int i = 0; i < 3; i++) lookup(32'h300, 1'b0, 1'b0, h, r, s);
      checks++; if (hit_cnt !== 32'hFFFFFFFF || miss_cnt !== 32'd1 || s !== 1'b0 || h !== 1'b0) begin failures++; $display("FAIL idle_no_count: got %h/%0d hit=%b stall=%b want ffffffff/1 0 0", hit_cnt, miss_cnt, h, s); end
      @(negedge CLK);
      force dut.miss_cnt_q = 32'hFFFFFFFF;
      #1;
      release dut.miss_cnt_q;
      lookup(32'h300, 1'b1, 1'b0, h, r, s);
      checks++; if (miss_cnt !== 32'hFFFFFFFF) begin failures++; $display("FAIL sat_miss: got %h want ffffffff", miss_cnt); end
      feed_beats(32'h300, LW, -1, -1, 1'b0, rq, st);
   endtask

   task automatic test_random();
      logic h, s; logic [31:0] r, pc, exp_r; logic exp_h, exp_s; bit fe, rq, st, all_v;
      int set, way, v, n; int unsigned tag;
      do_reset();
      for (int it = 0; it < 250; it++) begin
         pc = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 5)
            | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
         fe  = ($urandom_range(0, 4) != 0);
         set = int'(pc[8:5]);
         tag = 32'(pc[31:9]);
         if ($urandom_range(0, 49) == 0) begin
            lookup(pc, fe, 1'b1, h, r, s);
            count_stall(n);
            checks++; if (h !== 1'b0 || n != SETS) begin failures++; $display("FAIL rnd_flush: got hit=%b stalls=%0d want 0 %0d", h, n, SETS); end
            model_clear();
         end else begin
            way = -1;
            for (int w = 0; w < WAYS; w++) if (m_valid[set][w] && m_tag[set][w] == tag) way = w;
            lookup(pc, fe, 1'b0, h, r, s);
            if (!fe) begin
               exp_h = 1'b0; exp_r = NOP; exp_s = 1'b0;
            end else if (way >= 0) begin
               exp_h = 1'b1; exp_r = mem_word({pc[31:2], 2'b00}); exp_s = 1'b0; m_hits++;
            end else begin
               exp_h = 1'b0; exp_r = NOP; exp_s = 1'b1; m_misses++;
            end
            checks++; if ({h, r, s} !== {exp_h, exp_r, exp_s}) begin failures++; $display("FAIL rnd_lookup pc=%h: got hit=%b rd=%h stall=%b want %b %h %b", pc, h, r, s, exp_h, exp_r, exp_s); end
            if (fe && way < 0) begin
               feed_beats({pc[31:5], 5'b0}, LW, ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : -1, -1, 1'b0, rq, st);
               checks++; if (!(rq && st)) begin failures++; $display("FAIL rnd_refill pc=%h: got req_ok=%b stall_ok=%b want 1 1", pc, rq, st); end
               v = -1;
               for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[set][w]) v = w;
               all_v = (v < 0);
               if (all_v) v = m_vptr[set];
               m_valid[set][v] = 1'b1;
               m_tag[set][v]   = tag;
               if (all_v) m_vptr[set] = (v + 1) % WAYS;
            end
            checks++; if (hit_cnt !== m_hits || miss_cnt !== m_misses) begin failures++; $display("FAIL rnd_cnt: got %0d/%0d want %0d/%0d", hit_cnt, miss_cnt, m_hits, m_misses); end
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_miss_refill();
      test_replacement();
      test_flush();
      test_flush_in_refill();
      test_reset_mid_refill();
      test_saturation();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
